// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus bundle: ROM port, redirect request from execute and the
// fetch-queue output toward decode. The master side is the fetch sequencer.
interface ifetch_ctrl_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  modport master (
    output rom_addr,
    input  rom_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fault
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fault
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational
// ROM every cycle, buffers {pc, instr} pairs in a small FIFO toward decode,
// flushes on redirects and stops fetching on misaligned/out-of-range PCs.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          FQ_DEPTH  = 2,
  parameter int          ROM_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  ifetch_ctrl_if.master bus
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(FQ_DEPTH);
  localparam logic [29:0]   ROM_WORDS_C = 30'(ROM_WORDS);

  typedef enum logic {
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  rdPtr_q, rdPtr_d;
  logic [PW-1:0]  wrPtr_q, wrPtr_d;
  logic [31:0]    pcMem_q    [FQ_DEPTH];
  logic [31:0]    instrMem_q [FQ_DEPTH];

  logic inRange;
  logic full;
  logic pop;
  logic push;

  // Handshake terms; a redirect suppresses the push and the queue is flushed anyway.
  always_comb begin
    inRange = (pc_q[31:2] < ROM_WORDS_C);
    full    = (count_q == DEPTH_C);
    pop     = (count_q != '0) && bus.out_ready;
    push    = (state_q == ST_RUN) && !bus.redirect_valid && inRange && (!full || pop);
  end

  // Next-state logic: redirect wins over all queue bookkeeping.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    if (bus.redirect_valid) begin
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
      pc_d    = bus.redirect_pc;
      state_d = (bus.redirect_pc[1:0] == 2'b00) ? ST_RUN : ST_FAULT;
    end else begin
      if ((state_q == ST_RUN) && !inRange) begin
        state_d = ST_FAULT;
      end
      if (push) begin
        pc_d    = pc_q + 32'd4;
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
    end
  end

  // Queue storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pcMem_q[wrPtr_q]    <= pc_q;
      instrMem_q[wrPtr_q] <= bus.rom_instr;
    end
  end

  // Outputs come straight from registers, so out_valid never depends on out_ready.
  always_comb begin
    bus.rom_addr  = pc_q;
    bus.out_valid = (count_q != '0);
    bus.out_pc    = pcMem_q[rdPtr_q];
    bus.out_instr = instrMem_q[rdPtr_q];
    bus.fault     = (state_q == ST_FAULT);
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: a directed vector table, a short
// hand-written flush sequence and a randomized run against a queue model.
module tb_ifetch_ctrl;

  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ifetch_ctrl_if bus();

  ifetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (DEPTH),
    .ROM_WORDS(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // ROM contents: word i holds 0x13 + i*0x100080 (W0..W3 match the plan).
  function automatic logic [31:0] romWord(input logic [31:0] addr);
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    return 32'h0000_0013 + idx * 32'h0010_0080;
  endfunction

  assign bus.rom_instr = romWord(bus.rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        eValid;
    logic        eFault;
    logic [31:0] eAddr;
    logic [31:0] ePc;
    logic [31:0] eInstr;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic ef, input logic [31:0] ea,
                     input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.eValid = ev; v.eFault = ef; v.eAddr = ea; v.ePc = epc; v.eInstr = ei;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive inputs, let one rising edge pass, then settle 1 time unit after it.
  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic ev, input logic ef, input logic [31:0] ea,
                             input logic [31:0] epc, input logic [31:0] ei);
    cmp({nm, ".valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
    cmp({nm, ".fault"}, {31'd0, bus.fault}, {31'd0, ef});
    cmp({nm, ".addr"}, bus.rom_addr, ea);
    if (ev) begin
      cmp({nm, ".pc"}, bus.out_pc, epc);
      cmp({nm, ".instr"}, bus.out_instr, ei);
    end
  endtask

  // Behavioural reference: a queue of fetched words, a fetch PC and a fault flag.
  logic [31:0] mPcQ[$];
  logic [31:0] mInstrQ[$];
  logic [31:0] mPc;
  logic        mFault;

  task automatic modelStep(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit popped;
    bit canPush;
    if (r) begin
      mPcQ.delete(); mInstrQ.delete();
      mPc = 32'h0; mFault = 1'b0;
    end else if (rv) begin
      mPcQ.delete(); mInstrQ.delete();
      mPc = rpc; mFault = (rpc % 4) != 0;
    end else begin
      popped  = (mPcQ.size() > 0) && rdy;
      canPush = !mFault && (mPc < 32'h100) && ((mPcQ.size() < DEPTH) || popped);
      if (popped) begin
        void'(mPcQ.pop_front());
        void'(mInstrQ.pop_front());
      end
      if (!mFault && !(mPc < 32'h100)) mFault = 1'b1;
      if (canPush) begin
        mPcQ.push_back(mPc);
        mInstrQ.push_back(romWord(mPc));
        mPc = mPc + 32'd4;
      end
    end
  endtask

  localparam logic [31:0] W0  = 32'h0000_0013;
  localparam logic [31:0] W1  = 32'h0010_0093;
  localparam logic [31:0] W2  = 32'h0020_0113;
  localparam logic [31:0] W3  = 32'h0030_0193;
  localparam logic [31:0] W4  = 32'h0040_0213;
  localparam logic [31:0] W8  = 32'h0080_0413;
  localparam logic [31:0] W9  = 32'h0090_0493;
  localparam logic [31:0] W62 = 32'h03E0_1F13;
  localparam logic [31:0] W63 = 32'h03F0_1F93;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    #1;

    // Streaming from reset with decode always ready.
    row(1,0,0,1, 0,0,32'h00, 0,0);
    row(0,0,0,1, 1,0,32'h04, 32'h00,W0);
    row(0,0,0,1, 1,0,32'h08, 32'h04,W1);
    row(0,0,0,1, 1,0,32'h0C, 32'h08,W2);
    row(0,0,0,1, 1,0,32'h10, 32'h0C,W3);
    // Backpressure: queue fills at two entries, PC holds at 8.
    row(1,0,0,0, 0,0,32'h00, 0,0);
    row(0,0,0,0, 1,0,32'h04, 32'h00,W0);
    row(0,0,0,0, 1,0,32'h08, 32'h00,W0);
    row(0,0,0,0, 1,0,32'h08, 32'h00,W0);
    row(0,0,0,0, 1,0,32'h08, 32'h00,W0);
    row(0,0,0,1, 1,0,32'h0C, 32'h04,W1);
    row(0,0,0,1, 1,0,32'h10, 32'h08,W2);
    row(0,0,0,1, 1,0,32'h14, 32'h0C,W3);
    // Redirect to 0x20 with pcs 4/8 queued: they vanish.
    row(1,0,0,0, 0,0,32'h00, 0,0);
    row(0,0,0,0, 1,0,32'h04, 32'h00,W0);
    row(0,0,0,0, 1,0,32'h08, 32'h00,W0);
    row(0,0,0,1, 1,0,32'h0C, 32'h04,W1);
    row(0,1,32'h20,1, 0,0,32'h20, 0,0);
    row(0,0,0,1, 1,0,32'h24, 32'h20,W8);
    row(0,0,0,1, 1,0,32'h28, 32'h24,W9);
    // Misaligned redirect faults; an aligned redirect recovers.
    row(0,1,32'h22,1, 0,1,32'h22, 0,0);
    row(0,0,0,1, 0,1,32'h22, 0,0);
    row(0,0,0,0, 0,1,32'h22, 0,0);
    row(0,1,32'h10,1, 0,0,32'h10, 0,0);
    row(0,0,0,1, 1,0,32'h14, 32'h10,W4);
    // Last ROM word delivered, then out-of-range fault.
    row(0,1,32'hF8,1, 0,0,32'hF8, 0,0);
    row(0,0,0,1, 1,0,32'hFC, 32'hF8,W62);
    row(0,0,0,1, 1,0,32'h100, 32'hFC,W63);
    row(0,0,0,1, 0,1,32'h100, 0,0);
    row(0,0,0,1, 0,1,32'h100, 0,0);
    // Fault with a full queue: pre-fault entries still drain.
    row(0,1,32'hF8,0, 0,0,32'hF8, 0,0);
    row(0,0,0,0, 1,0,32'hFC, 32'hF8,W62);
    row(0,0,0,0, 1,0,32'h100, 32'hF8,W62);
    row(0,0,0,0, 1,1,32'h100, 32'hF8,W62);
    row(0,0,0,1, 1,1,32'h100, 32'hFC,W63);
    row(0,0,0,1, 0,1,32'h100, 0,0);
    // Reset beats a simultaneous redirect with a full queue.
    row(0,1,32'h00,0, 0,0,32'h00, 0,0);
    row(0,0,0,0, 1,0,32'h04, 32'h00,W0);
    row(0,0,0,0, 1,0,32'h08, 32'h00,W0);
    row(1,1,32'h40,1, 0,0,32'h00, 0,0);
    row(0,0,0,1, 1,0,32'h04, 32'h00,W0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      checkOutput($sformatf("row%0d", i), vecs[i].eValid, vecs[i].eFault, vecs[i].eAddr,
                  vecs[i].ePc, vecs[i].eInstr);
    end

    // Misaligned redirect against a full queue, then recovery at the last word.
    applyStimulus(1,0,32'h0,0);
    applyStimulus(0,0,32'h0,0);
    applyStimulus(0,0,32'h0,0);
    checkOutput("seqFull", 1,0,32'h08, 32'h00,W0);
    applyStimulus(0,1,32'h13,1);
    checkOutput("seqMisal", 0,1,32'h13, 0,0);
    applyStimulus(0,0,32'h0,1);
    checkOutput("seqHold", 0,1,32'h13, 0,0);
    applyStimulus(0,1,32'hFC,1);
    checkOutput("seqRecover", 0,0,32'hFC, 0,0);
    applyStimulus(0,0,32'h0,1);
    checkOutput("seqLast", 1,0,32'h100, 32'hFC,W63);
    applyStimulus(0,0,32'h0,1);
    checkOutput("seqEnd", 0,1,32'h100, 0,0);

    // Randomized run against the reference model.
    modelStep(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: rpc = 32'($urandom_range(0, 63)) << 2;
        1: rpc = 32'hF0 + (32'($urandom_range(0, 3)) << 2);
        2: rpc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        default: rpc = 32'h400 + (32'($urandom_range(0, 15)) << 2);
      endcase
      modelStep(r, rv, rpc, rdy);
      applyStimulus(r, rv, rpc, rdy);
      checkOutput($sformatf("rnd%0d", n), mPcQ.size() != 0, mFault, mPc,
                  (mPcQ.size() != 0) ? mPcQ[0] : 32'h0,
                  (mInstrQ.size() != 0) ? mInstrQ[0] : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
